// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// Holds the default widths, the FSM state type and the round-robin pick function.
package sdram_arb_pkg;

   localparam int MAX_REQ       = 8;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_ADDR_W    = 24;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_TAG_DEPTH = 4;

   typedef enum logic {ARB, CMD} arb_state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // First set bit of mask at or after ptr, wrapping modulo n.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                        input logic [2:0]         ptr,
                                        input int                 n);
      rr_pick_t r;
      int       k;
      r = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         k = (int'(ptr) + i) % n;
         if (i < n && !r.found && mask[k[2:0]]) begin
            r.found = 1'b1;
            r.idx   = k[2:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of requester indices for read bursts in flight; head is
// combinational, push/pop take effect on the clock edge.
module sdram_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = DEF_TAG_DEPTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rd_ptr];
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one SDRAM driver between NUM_REQ requesters; one command per
// two cycles, read responses steered back to their issuer through an in-order tag FIFO.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
   input  logic                          clk_axi,
   input  logic                          rst_axi,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic                          rsp_last_o,
   output logic [DATA_W-1:0]             rsp_data_o,
   input  logic [NUM_REQ-1:0]            rsp_ready_i,
   output logic                          reader_valid_o,
   input  logic                          reader_ready_i,
   output logic [ADDR_W-1:0]             reader_addr_o,
   output logic                          writer_valid_o,
   input  logic                          writer_ready_i,
   output logic [ADDR_W-1:0]             writer_addr_o,
   output logic [DATA_W-1:0]             writer_data_o,
   input  logic                          resp_valid_i,
   input  logic                          resp_last_i,
   input  logic [DATA_W-1:0]             resp_data_i,
   output logic                          resp_ready_o,
   output logic [$clog2(TAG_DEPTH):0]    outstanding_o,
   output logic                          error_orphan_o
);
   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_grant;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_orphan;

   logic [NUM_REQ-1:0]  w_elig;
   logic [MAX_REQ-1:0]  w_mask;
   rr_pick_t            w_pick;
   logic [IDX_W-1:0]    w_pick_idx;
   logic [IDX_W-1:0]    w_grant_inc;
   logic                w_cmd_hs;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [IDX_W-1:0]    w_head;

   // Reads are held back while every tag slot is in use; writes never need a tag.
   always_comb begin
      w_elig = req_valid_i & (req_we_i | {NUM_REQ{~w_full}});
      w_mask = '0;
      w_mask[NUM_REQ-1:0] = w_elig;
      w_pick = rr_pick(w_mask, 3'(r_rr_ptr), NUM_REQ);
      w_pick_idx = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (w_pick.idx == 3'(k)) w_pick_idx = IDX_W'(k);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_hs    = 1'b0;
      case (r_state)
         ARB: if (w_pick.found) w_state_nxt = CMD;
         CMD: begin
            w_cmd_hs = r_we ? writer_ready_i : reader_ready_i;
            if (w_cmd_hs) w_state_nxt = ARB;
         end
         default: w_state_nxt = ARB;
      endcase
   end

   assign w_grant_inc = (r_grant == IDX_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;

   always_ff @(posedge clk_axi) begin
      if (rst_axi) begin
         r_state  <= ARB;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_orphan <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ARB && w_pick.found) begin
            r_grant <= w_pick_idx;
            r_we    <= req_we_i[w_pick_idx];
            r_addr  <= req_addr_i[w_pick_idx*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata_i[w_pick_idx*DATA_W +: DATA_W];
         end
         if (w_cmd_hs) r_rr_ptr <= w_grant_inc;
         if (resp_valid_i && w_empty) r_orphan <= 1'b1;
      end
   end

   assign reader_valid_o = (r_state == CMD) && !r_we;
   assign writer_valid_o = (r_state == CMD) && r_we;
   assign reader_addr_o  = r_addr;
   assign writer_addr_o  = r_addr;
   assign writer_data_o  = r_wdata;

   always_comb begin
      req_ready_o = '0;
      if (w_cmd_hs) req_ready_o[r_grant] = 1'b1;
   end

   // With no tag at the head the word is orphaned: nobody is offered it and it is not consumed.
   always_comb begin
      rsp_valid_o  = '0;
      resp_ready_o = 1'b0;
      if (!w_empty) begin
         rsp_valid_o[w_head] = resp_valid_i;
         resp_ready_o        = rsp_ready_i[w_head];
      end
   end

   assign rsp_last_o     = resp_last_i;
   assign rsp_data_o     = resp_data_i;
   assign error_orphan_o = r_orphan;
   assign w_push         = w_cmd_hs && !r_we;
   assign w_pop          = resp_valid_i && resp_ready_o && resp_last_i;

   sdram_tag_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .i_clk      (clk_axi),
      .i_rst      (rst_axi),
      .i_push     (w_push),
      .i_push_dat (r_grant),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (outstanding_o)
   );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: bench-side requesters and SDRAM driver, checked against a
// transaction-level model (pending requests, queue of outstanding reads in issue order).
module tb_sdram_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TD = 4;

   logic            clk_axi = 1'b0;
   logic            rst_axi;
   logic [N-1:0]    req_valid_i, req_ready_o, req_we_i;
   logic [N*AW-1:0] req_addr_i;
   logic [N*DW-1:0] req_wdata_i;
   logic [N-1:0]    rsp_valid_o, rsp_ready_i;
   logic            rsp_last_o;
   logic [DW-1:0]   rsp_data_o;
   logic            reader_valid_o, reader_ready_i;
   logic [AW-1:0]   reader_addr_o;
   logic            writer_valid_o, writer_ready_i;
   logic [AW-1:0]   writer_addr_o;
   logic [DW-1:0]   writer_data_o;
   logic            resp_valid_i, resp_last_i, resp_ready_o;
   logic [DW-1:0]   resp_data_i;
   logic [2:0]      outstanding_o;
   logic            error_orphan_o;

   always #5 clk_axi = ~clk_axi;

   sdram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
      .clk_axi(clk_axi), .rst_axi(rst_axi),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_last_o(rsp_last_o), .rsp_data_o(rsp_data_o),
      .rsp_ready_i(rsp_ready_i),
      .reader_valid_o(reader_valid_o), .reader_ready_i(reader_ready_i), .reader_addr_o(reader_addr_o),
      .writer_valid_o(writer_valid_o), .writer_ready_i(writer_ready_i), .writer_addr_o(writer_addr_o),
      .writer_data_o(writer_data_o),
      .resp_valid_i(resp_valid_i), .resp_last_i(resp_last_i), .resp_data_i(resp_data_i),
      .resp_ready_o(resp_ready_o),
      .outstanding_o(outstanding_o), .error_orphan_o(error_orphan_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Requester and driver model state.
   logic [N-1:0]  vld, we, rrdy;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] wd [N];
   int            refill [N];
   int            n_acc [N];
   int            words_to [N];
   bit            rand_req, rand_rdy, rand_rrdy, rand_resp, resp_en;
   bit            wr_rdy, rd_rdy, hold, orphan_m, orphan_pulse;
   int            burst_len, word, bp_cnt, bp_seen, cyc;
   int            tagq [$];
   int            lens [$];
   int            grant_log [$];
   int            grant_cyc [$];

   task automatic new_req(input int k, input logic is_we);
      vld[k]  = 1'b1;
      we[k]   = is_we;
      addr[k] = AW'($urandom);
      wd[k]   = DW'($urandom);
   endtask

   task automatic step();
      int           g;
      logic         hs_w, hs_r, exp_rr;
      logic [N-1:0] exp_rv;
      @(negedge clk_axi);
      if (rand_req)
         for (int k = 0; k < N; k++)
            if (!vld[k] && $urandom_range(3) == 0) new_req(k, 1'($urandom_range(1)));
      req_valid_i = vld;
      req_we_i    = we;
      for (int k = 0; k < N; k++) begin
         req_addr_i[k*AW +: AW]  = addr[k];
         req_wdata_i[k*DW +: DW] = wd[k];
      end
      writer_ready_i = rand_rdy ? 1'($urandom_range(1)) : wr_rdy;
      reader_ready_i = rand_rdy ? 1'($urandom_range(1)) : rd_rdy;
      rsp_ready_i    = rand_rrdy ? N'($urandom) : rrdy;
      if (!hold) begin
         resp_valid_i = 1'b0;
         resp_last_i  = 1'b0;
         if (orphan_pulse) begin
            resp_valid_i = 1'b1;
            resp_data_i  = DW'($urandom);
            orphan_pulse = 1'b0;
         end else if (resp_en && lens.size() > 0 && (!rand_resp || $urandom_range(3) != 0)) begin
            resp_valid_i = 1'b1;
            resp_data_i  = DW'($urandom);
            resp_last_i  = (word == lens[0] - 1);
         end
      end
      if (bp_cnt > 0 && word == 1 && resp_valid_i) begin
         rsp_ready_i = '0;
         bp_cnt--;
      end
      #1;
      chk("outstanding", outstanding_o, tagq.size());
      chk("orphan", error_orphan_o, orphan_m);
      exp_rv = '0;
      exp_rr = 1'b0;
      if (tagq.size() > 0) begin
         exp_rr = rsp_ready_i[tagq[0]];
         if (resp_valid_i) exp_rv[tagq[0]] = 1'b1;
      end
      chk("rsp_valid", rsp_valid_o, exp_rv);
      chk("resp_ready", resp_ready_o, exp_rr);
      if (resp_valid_i) begin
         chk("rsp_data", rsp_data_o, resp_data_i);
         chk("rsp_last", rsp_last_o, resp_last_i);
      end
      hs_w = writer_valid_o & writer_ready_i;
      hs_r = reader_valid_o & reader_ready_i;
      chk("one_cmd", hs_w & hs_r, 0);
      g = 0;
      if (hs_w | hs_r) begin
         chk("rdy_onehot", $onehot(req_ready_o), 1);
         for (int k = 0; k < N; k++) if (req_ready_o[k]) g = k;
         chk("cmd_vld", vld[g], 1);
         chk("cmd_we", hs_w, we[g]);
         chk("cmd_addr", hs_w ? writer_addr_o : reader_addr_o, addr[g]);
         if (hs_w) chk("cmd_data", writer_data_o, wd[g]);
      end else begin
         chk("rdy_idle", req_ready_o, 0);
      end
      // Advance the model as the coming clock edge will.
      if (resp_valid_i && tagq.size() == 0) orphan_m = 1'b1;
      if (resp_valid_i && !resp_ready_o) bp_seen++;
      if (resp_valid_i && resp_ready_o && tagq.size() > 0) begin
         words_to[tagq[0]]++;
         if (resp_last_i) begin
            void'(tagq.pop_front());
            void'(lens.pop_front());
            word = 0;
         end else begin
            word++;
         end
      end
      hold = resp_valid_i && !resp_ready_o && lens.size() > 0;
      if (hs_w | hs_r) begin
         vld[g] = 1'b0;
         n_acc[g]++;
         grant_log.push_back(g);
         grant_cyc.push_back(cyc);
         if (hs_r) begin
            tagq.push_back(g);
            lens.push_back(burst_len > 0 ? burst_len : int'($urandom_range(4, 1)));
         end
         if (refill[g] > 0) begin
            refill[g]--;
            new_req(g, we[g]);
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk_axi);
      rst_axi = 1'b1;
      req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = '0;
      reader_ready_i = 1'b0; writer_ready_i = 1'b0;
      resp_valid_i = 1'b0; resp_last_i = 1'b0; resp_data_i = '0;
      vld = '0; we = '0; rrdy = '1;
      for (int k = 0; k < N; k++) begin
         refill[k] = 0; n_acc[k] = 0; words_to[k] = 0; addr[k] = '0; wd[k] = '0;
      end
      rand_req = 0; rand_rdy = 0; rand_rrdy = 0; rand_resp = 0; resp_en = 0;
      wr_rdy = 0; rd_rdy = 0; hold = 0; orphan_m = 0; orphan_pulse = 0;
      burst_len = 8; word = 0; bp_cnt = 0; bp_seen = 0; cyc = 0;
      tagq.delete(); lens.delete(); grant_log.delete(); grant_cyc.delete();
      @(negedge clk_axi);
      rst_axi = 1'b0;
      #1;
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rd_valid", reader_valid_o, 0);
      chk("rst_wr_valid", writer_valid_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_resp_ready", resp_ready_o, 0);
      chk("rst_rd_addr", reader_addr_o, 0);
      chk("rst_wr_addr", writer_addr_o, 0);
      chk("rst_wr_data", writer_data_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_orphan", error_orphan_o, 0);
   endtask

   initial begin
      int       seq [$];
      int       last, n;
      bit       done;
      int       exp_order [6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      rst_axi = 1'b1;
      do_reset();

      // Single write from requester 2.
      addr[2] = 24'h000100; wd[2] = 16'hBEEF; we[2] = 1'b1; vld[2] = 1'b1; wr_rdy = 1;
      step();
      chk("A_wv_early", writer_valid_o, 0);
      step();
      chk("A_wv", writer_valid_o, 1);
      chk("A_addr", writer_addr_o, 24'h000100);
      chk("A_data", writer_data_o, 16'hBEEF);
      chk("A_rdy", req_ready_o, 4'b0100);
      step();
      chk("A_rdy_pulse", req_ready_o, 0);
      chk("A_wv_drop", writer_valid_o, 0);
      chk("A_outst", outstanding_o, 0);

      // Fairness with all four writing continuously.
      do_reset();
      wr_rdy = 1;
      for (int k = 0; k < N; k++) begin
         new_req(k, 1'b1);
         refill[k] = 10;
      end
      repeat (14) step();
      chk("B_count", grant_log.size() >= 6, 1);
      if (grant_log.size() >= 6)
         for (int i = 0; i < 6; i++) begin
            chk("B_order", grant_log[i], exp_order[i]);
            if (i > 0) chk("B_spacing", grant_cyc[i] - grant_cyc[i-1], 2);
         end

      // Two read bursts routed back to requesters 1 and 3.
      do_reset();
      rd_rdy = 1; resp_en = 1; burst_len = 8;
      new_req(1, 1'b0); addr[1] = 24'h10;
      new_req(3, 1'b0); addr[3] = 24'h20;
      last = 0; done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         if (int'(outstanding_o) != last) begin
            last = int'(outstanding_o);
            seq.push_back(last);
         end
         done = (vld == '0) && (tagq.size() == 0) && (outstanding_o == 0);
      end
      chk("C_done", done, 1);
      chk("C_seq_len", seq.size(), 4);
      if (seq.size() == 4) begin
         chk("C_seq0", seq[0], 1); chk("C_seq1", seq[1], 2);
         chk("C_seq2", seq[2], 1); chk("C_seq3", seq[3], 0);
      end
      chk("C_words1", words_to[1], 8);
      chk("C_words3", words_to[3], 8);
      chk("C_words0", words_to[0] + words_to[2], 0);

      // Tag FIFO full: fifth read stalls, a write still gets through.
      do_reset();
      rd_rdy = 1; wr_rdy = 1; burst_len = 2;
      new_req(0, 1'b0);
      refill[0] = 4;
      repeat (14) step();
      chk("D_acc4", n_acc[0], 4);
      chk("D_full", outstanding_o, 4);
      chk("D_stalled", vld[0], 1);
      new_req(1, 1'b1);
      for (int i = 0; i < 6 && n_acc[1] == 0; i++) step();
      chk("D_write", n_acc[1], 1);
      chk("D_still_stalled", n_acc[0], 4);
      resp_en = 1;
      for (int i = 0; i < 20 && n_acc[0] < 5; i++) step();
      chk("D_acc5", n_acc[0], 5);
      for (int i = 0; i < 40 && tagq.size() > 0; i++) step();
      chk("D_drain", tagq.size(), 0);

      // Response backpressure mid-burst.
      do_reset();
      rd_rdy = 1; resp_en = 1; burst_len = 4; bp_cnt = 3;
      new_req(2, 1'b0);
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         done = (vld == '0) && (tagq.size() == 0);
      end
      chk("E_done", done, 1);
      chk("E_bp_cycles", bp_seen, 3);
      chk("E_words", words_to[2], 4);

      // Orphan response is sticky until reset; reset also drops a pending command.
      do_reset();
      orphan_pulse = 1;
      step();
      step();
      chk("F_orphan_set", error_orphan_o, 1);
      repeat (3) step();
      chk("F_orphan_sticky", error_orphan_o, 1);
      new_req(0, 1'b0);
      repeat (3) step();
      chk("F_rd_pending", reader_valid_o, 1);
      do_reset();

      // Randomised traffic, then drain.
      rand_req = 1; rand_rdy = 1; rand_rrdy = 1; rand_resp = 1; resp_en = 1; burst_len = 0;
      repeat (3000) step();
      rand_req = 0;
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         step();
         done = (vld == '0) && (tagq.size() == 0);
      end
      chk("G_drained", done, 1);
      n = 0;
      for (int k = 0; k < N; k++) n += n_acc[k];
      chk("G_traffic", n > 100, 1);
      chk("G_orphan", error_orphan_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single reader/writer/response interface of SdramDriver between NUM_REQ independent requesters (tester, video fetch, CPU bridge).
- Round-robin arbitration, one command per grant.
- Read bursts are tagged in an in-order tag FIFO, and each response burst is routed back to the requester that issued it.
- Sits in the clk_axi domain, between the requester blocks and SdramDriver.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 24: command address width.
- DATA_W, 16: data width.
- TAG_DEPTH, 4: outstanding read bursts tracked (power of 2).

Ports:
- clk_axi  in  1  system clock.
- rst_axi  in  1  synchronous reset, active high.
- req_valid_i  in  NUM_REQ  per-requester command valid.
- req_ready_o  out  NUM_REQ  per-requester command accepted.
- req_we_i  in  NUM_REQ  1 = write, 0 = read burst.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid_o  out  NUM_REQ  response word valid.
- rsp_last_o  out  1  last word of burst (shared).
- rsp_data_o  out  DATA_W  response data (shared).
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- reader_valid_o / reader_ready_i / reader_addr_o  out/in/out  1/1/ADDR_W  to driver read port.
- writer_valid_o / writer_ready_i / writer_addr_o / writer_data_o  out/in/out/out  1/1/ADDR_W/DATA_W  to driver write port.
- resp_valid_i / resp_last_i / resp_data_i / resp_ready_o  in/in/in/out  1/1/DATA_W/1  from driver.
- outstanding_o  out  $clog2(TAG_DEPTH)+1  number of read bursts in flight.
- error_orphan_o  out  1  sticky: resp_valid_i seen while tag FIFO empty.

Behaviour:
- Clock and reset: single clock clk_axi; rst_axi is synchronous, active high.
- Reset values:
  - req_ready_o, reader_valid_o, writer_valid_o, rsp_valid_o and resp_ready_o are 0.
  - Address and data outputs are 0.
  - outstanding_o is 0 and error_orphan_o is 0.
  - Round-robin pointer is 0; tag FIFO is empty.
- Eligibility: requester k is eligible when req_valid_i[k] is high and either req_we_i[k]=1 or the tag FIFO is not full.
- FSM, state ARB:
  - Picks the first eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Registers grant index, we, addr and wdata, then moves to CMD.
  - With no eligible requester, stays in ARB.
- FSM, state CMD:
  - Drives writer_valid_o (we=1) or reader_valid_o (we=0) from the registered values.
  - Holds them until the matching *_ready_i is high.
  - On that handshake cycle it:
    - pulses req_ready_o[grant] for exactly that cycle;
    - for a read, pushes grant into the tag FIFO;
    - sets rr_ptr = grant+1 (wrap);
    - returns to ARB.
  - Requesters must hold valid/we/addr/wdata stable until req_ready_o. The arbiter never retracts a granted command.
- Latency and throughput:
  - Minimum latency from req_valid_i to driver valid is 1 cycle (registered).
  - Maximum rate is one command per 2 cycles.
- Response routing (combinational from FIFO head):
  - If the FIFO is not empty: rsp_valid_o[head] = resp_valid_i; all other bits are 0; resp_ready_o = rsp_ready_i[head].
  - If the FIFO is empty: resp_ready_o = 0 and all rsp_valid_o = 0.
  - rsp_last_o and rsp_data_o pass through directly.
  - The head is popped on the cycle where resp_valid_i & resp_ready_o & resp_last_i is high.
- Tag FIFO boundaries:
  - A simultaneous push and pop leaves the count unchanged and the data is correct.
  - A read is not eligible when the FIFO is full, so no overflow is possible.
  - outstanding_o equals the FIFO count.
- Orphan response: resp_valid_i=1 while the FIFO is empty sets error_orphan_o. It clears only on reset. The word is not consumed (resp_ready_o stays 0).
- Reset mid-operation: any in-flight command and all tags are dropped. The driver is reset together with the arbiter (same reset source).
- Fairness: with all requesters permanently eligible, grants follow the order 0,1,2,3,0,...

Decomposition:
- sdram_arb_pkg:
  - localparams for default widths;
  - typedef arb_state_t {ARB, CMD};
  - function rr_pick(mask, ptr) returning index and found flag.
- One sub-module: sdram_tag_fifo (synchronous FIFO, width $clog2(NUM_REQ), depth TAG_DEPTH, with full/empty/count).

Test Plan:
- Single write from requester 2, addr 0x000100, data 0xBEEF, writer_ready_i high:
  - writer_valid_o rises 1 cycle after req_valid_i, with addr 0x000100 and data 0xBEEF;
  - req_ready_o = 4'b0100 for one cycle;
  - outstanding_o stays 0.
- All 4 requesters requesting writes continuously, writer_ready_i=1: grant order is 0,1,2,3,0,1, one command every 2 cycles.
- Requester 1 reads 0x10, then requester 3 reads 0x20; driver returns 2 bursts of 8 words with last on word 8:
  - first burst appears only on rsp_valid_o[1], second only on rsp_valid_o[3];
  - outstanding_o goes 1→2→1→0.
- TAG_DEPTH=4, driver withholds responses, requester 0 issues 5 reads:
  - 4 accepted, the 5th is stalled with req_ready_o[0]=0;
  - a write from requester 1 is still granted;
  - after one burst completes, the 5th read is accepted.
- Backpressure: rsp_ready_i[head]=0 for 3 cycles mid-burst → resp_ready_o=0 for those cycles and the data word is held; no pop until last is accepted.
- resp_valid_i pulse with FIFO empty → error_orphan_o=1 and stays 1; rst_axi for 1 cycle → all outputs return to reset values and error_orphan_o=0.
